// File: rtl/rv32i_data_bus.sv
// RV32I data-side bus: word-addressed data RAM, GPIO and an optional compare timer.
// Define RV32I_DATA_BUS_TIMER_EN to build the timer block; without it the TIMER_* slots read 0.
module rv32i_data_bus #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Memwrite,
  input  logic [31:0] Memaddr,
  input  logic [31:0] MemWdata,
  output logic [31:0] MemRdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  // MMIO word addresses (byte address >> 2)
  localparam logic [29:0] A_GPIO_OUT = 30'h3FFF_C000;
  localparam logic [29:0] A_GPIO_IN  = 30'h3FFF_C001;
`ifdef RV32I_DATA_BUS_TIMER_EN
  localparam logic [29:0] A_TCTRL    = 30'h3FFF_C004;
  localparam logic [29:0] A_TCNT     = 30'h3FFF_C005;
  localparam logic [29:0] A_TCMP     = 30'h3FFF_C006;
  localparam logic [29:0] A_TSTAT    = 30'h3FFF_C007;
`endif

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_off;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    unused_off;
  logic [29:0]   wa;
  logic          mmio_we;

  logic [15:0]   gpio_out;
  logic [15:0]   sw_sync1;
  logic [15:0]   sw_sync2;

  assign ram_off    = Memaddr - RAM_BASE;
  assign ram_hit    = ram_off < RAM_BYTES;
  assign ram_idx    = ram_off[AW+1:2];
  assign unused_off = ram_off[1:0];
  assign wa         = Memaddr[31:2];
  assign mmio_we    = Memwrite && !ram_hit;
  assign led_out    = gpio_out;

`ifdef RV32I_DATA_BUS_TIMER_EN
  logic [2:0]  timer_ctrl;
  logic [31:0] timer_cnt;
  logic [31:0] timer_cmp;
  logic        timer_flag;
  logic        timer_match;

  assign timer_match = timer_ctrl[0] && (timer_cnt == timer_cmp);
  assign timer_irq   = timer_flag && timer_ctrl[2];
`else
  assign timer_irq = 1'b0;
`endif

  // RAM has no reset value; it sits in this block only so reset also blocks its writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out   <= '0;
      sw_sync1   <= '0;
      sw_sync2   <= '0;
`ifdef RV32I_DATA_BUS_TIMER_EN
      timer_ctrl <= '0;
      timer_cnt  <= '0;
      timer_cmp  <= 32'hFFFF_FFFF;
      timer_flag <= 1'b0;
`endif
    end else begin
      sw_sync1 <= sw_in;
      sw_sync2 <= sw_sync1;
      if (Memwrite && ram_hit)
        ram[ram_idx] <= MemWdata;
      if (mmio_we && wa == A_GPIO_OUT)
        gpio_out <= MemWdata[15:0];
`ifdef RV32I_DATA_BUS_TIMER_EN
      if (mmio_we && wa == A_TCTRL)
        timer_ctrl <= MemWdata[2:0];
      if (mmio_we && wa == A_TCMP)
        timer_cmp <= MemWdata;
      // CPU write beats reload, reload beats increment
      if (mmio_we && wa == A_TCNT)
        timer_cnt <= MemWdata;
      else if (timer_match && timer_ctrl[1])
        timer_cnt <= '0;
      else if (timer_ctrl[0])
        timer_cnt <= timer_cnt + 32'd1;
      // a match in the same cycle as W1C keeps the flag set
      if (timer_match)
        timer_flag <= 1'b1;
      else if (mmio_we && wa == A_TSTAT && MemWdata[0])
        timer_flag <= 1'b0;
`endif
    end
  end

  always_comb begin
    MemRdata = '0;
    if (ram_hit) begin
      MemRdata = ram[ram_idx];
    end else begin
      case (wa)
        A_GPIO_OUT: MemRdata = {16'h0, gpio_out};
        A_GPIO_IN:  MemRdata = {16'h0, sw_sync2};
`ifdef RV32I_DATA_BUS_TIMER_EN
        A_TCTRL:    MemRdata = {29'h0, timer_ctrl};
        A_TCNT:     MemRdata = timer_cnt;
        A_TCMP:     MemRdata = timer_cmp;
        A_TSTAT:    MemRdata = {31'h0, timer_flag};
`endif
        default:    MemRdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_data_bus.sv
// Scoreboard bench for rv32i_data_bus: stimulus pushes expected read/led/irq values from a
// behavioural model; a negedge monitor pops and compares them against the DUT.
module tb_rv32i_data_bus;

  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] GPIO_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_IN   = 32'hFFFF_0004;
  localparam logic [31:0] T_CTRL    = 32'hFFFF_0010;
  localparam logic [31:0] T_CNT     = 32'hFFFF_0014;
  localparam logic [31:0] T_CMP     = 32'hFFFF_0018;
  localparam logic [31:0] T_STAT    = 32'hFFFF_001C;
`ifdef RV32I_DATA_BUS_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Memwrite;
  logic [31:0] Memaddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        timer_irq;

  always #5 clk = ~clk;

  rv32i_data_bus #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE)) dut (
    .clk(clk), .reset(reset), .Memwrite(Memwrite), .Memaddr(Memaddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata), .sw_in(sw_in),
    .led_out(led_out), .timer_irq(timer_irq)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    bit          rd_chk;
    logic [15:0] led;
    bit          irq;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // behavioural model state
  logic [31:0] m_ram [int];
  logic [15:0] m_gpio, m_s1, m_s2;
  logic [2:0]  m_ctrl;
  logic [31:0] m_cnt, m_cmp;
  bit          m_flag;

  function automatic void m_reset();
    m_gpio = '0; m_s1 = '0; m_s2 = '0;
    m_ctrl = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_flag = 1'b0;
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return (longint'(a) >= longint'(RAM_BASE)) &&
           (longint'(a) <  longint'(RAM_BASE) + 4 * RAM_WORDS);
  endfunction

  function automatic void m_read(input logic [31:0] a, output logic [31:0] v, output bit ok);
    logic [31:0] w;
    int idx;
    ok = 1'b1;
    v  = '0;
    w  = a & 32'hFFFF_FFFC;
    if (in_ram(a)) begin
      idx = int'((a - RAM_BASE) / 4);
      if (m_ram.exists(idx)) v = m_ram[idx];
      else ok = 1'b0;
    end else if (w == GPIO_OUT) v = {16'h0, m_gpio};
    else if (w == GPIO_IN) v = {16'h0, m_s2};
    else if (TIMER_ON) begin
      if (w == T_CTRL) v = {29'h0, m_ctrl};
      else if (w == T_CNT) v = m_cnt;
      else if (w == T_CMP) v = m_cmp;
      else if (w == T_STAT) v = {31'h0, m_flag};
    end
  endfunction

  function automatic void m_edge(input bit we, input logic [31:0] a, input logic [31:0] d,
                                 input logic [15:0] sw, input bit rst);
    logic [31:0] w, n_cnt;
    bit match, n_flag;
    if (rst) begin
      m_reset();
      return;
    end
    w = a & 32'hFFFF_FFFC;
    n_cnt  = m_cnt;
    n_flag = m_flag;
    if (TIMER_ON) begin
      match = m_ctrl[0] && (m_cnt == m_cmp);
      if (we && w == T_CNT) n_cnt = d;
      else if (match && m_ctrl[1]) n_cnt = 0;
      else if (m_ctrl[0]) n_cnt = m_cnt + 1;
      if (match) n_flag = 1'b1;
      else if (we && w == T_STAT && d[0]) n_flag = 1'b0;
      if (we && w == T_CTRL) m_ctrl = d[2:0];
      if (we && w == T_CMP) m_cmp = d;
    end
    m_cnt  = n_cnt;
    m_flag = n_flag;
    if (we && in_ram(a)) m_ram[int'((a - RAM_BASE) / 4)] = d;
    else if (we && w == GPIO_OUT) m_gpio = d[15:0];
    m_s2 = m_s1;
    m_s1 = sw;
  endfunction

  // one bus cycle: called at posedge+1, returns at next posedge+1
  task automatic cyc(input string nm, input bit we, input logic [31:0] a,
                     input logic [31:0] d = 32'h0);
    exp_t e;
    logic [31:0] v;
    bit ok;
    Memwrite = we;
    Memaddr  = a;
    MemWdata = d;
    if (reset) m_reset();
    m_read(a, v, ok);
    e.name = nm; e.rd = v; e.rd_chk = ok;
    e.led = m_gpio; e.irq = m_flag && m_ctrl[2];
    q.push_back(e);
    @(posedge clk);
    m_edge(we, a, d, sw_in, reset);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rd_chk) check({e.name, "/rdata"}, MemRdata, e.rd);
      check({e.name, "/led"}, {16'h0, led_out}, {16'h0, e.led});
      check({e.name, "/irq"}, {31'h0, timer_irq}, {31'h0, e.irq});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    int r;
    reset = 1'b1; Memwrite = 1'b0; Memaddr = '0; MemWdata = '0; sw_in = '0;
    m_reset();
    @(posedge clk); #1;
    cyc("rst_gpio", 0, GPIO_OUT);
    cyc("rst_cmp", 0, T_CMP);
    cyc("rst_ctrl", 0, T_CTRL);
    reset = 1'b0;

    cyc("ram_wr", 1, 32'h1000_0004, 32'hDEAD_BEEF);
    cyc("ram_rd", 0, 32'h1000_0004);
    cyc("ram_rd_off", 0, 32'h1000_0006);
    cyc("gpio_wr", 1, GPIO_OUT, 32'h0001_A5A5);
    cyc("gpio_rd", 0, GPIO_OUT);
    sw_in = 16'h1234;
    for (int i = 0; i < 3; i++) cyc("gpio_in", 0, GPIO_IN);
    cyc("unmapped", 0, 32'h2000_0000);
    cyc("wr_gpio_in", 1, GPIO_IN, 32'hFFFF_FFFF);
    cyc("rd_gpio_in", 0, GPIO_IN);

    cyc("cmp5", 1, T_CMP, 5);
    cyc("cnt0", 1, T_CNT, 0);
    cyc("ctrl7", 1, T_CTRL, 7);
    for (int i = 0; i < 8; i++) cyc("cnt_run", 0, T_CNT);
    cyc("stat", 0, T_STAT);
    cyc("w1c", 1, T_STAT, 1);
    cyc("post_w1c", 0, T_STAT);
    cyc("w1c_match", 1, T_STAT, 1);
    cyc("set_wins", 0, T_STAT);

    cyc("cmpmax", 1, T_CMP, 32'hFFFF_FFFF);
    cyc("ctrl1", 1, T_CTRL, 1);
    cyc("cnt_fe", 1, T_CNT, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) cyc("wrap", 0, T_CNT);
    cyc("cnt7", 1, T_CNT, 7);
    cyc("cnt7_rd", 0, T_CNT);

    cyc("cmp100", 1, T_CMP, 100);
    cyc("cnt95", 1, T_CNT, 95);
    cyc("ctrl5", 1, T_CTRL, 5);
    for (int i = 0; i < 8; i++) cyc("to100", 0, T_CNT);
    reset = 1'b1;
    cyc("rst_cnt", 0, T_CNT);
    cyc("rst_wr", 1, 32'h1000_0004, 32'h1111_1111);
    cyc("rst_led", 0, GPIO_OUT);
    reset = 1'b0;
    cyc("ram_kept", 0, 32'h1000_0004);
    cyc("flag_clr", 0, T_STAT);

    for (int i = 0; i < 400; i++) begin
      sw_in = 16'($urandom);
      r = $urandom_range(0, 9);
      d = $urandom;
      case (r)
        0, 1, 2, 3: a = RAM_BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        4: a = GPIO_OUT;
        5: a = GPIO_IN;
        6: a = T_CTRL;
        7: begin a = T_CNT; d = $urandom_range(0, 40); end
        8: begin a = T_CMP; d = $urandom_range(0, 40); end
        default: a = ($urandom_range(0, 1) == 1) ? T_STAT : 32'hFFFF_0008;
      endcase
      cyc("rand", 1'($urandom_range(0, 1)), a, d);
    end

    Memwrite = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
